rs232_tx_arbiter: RTL and testbench

- Shares the single transmit channel of the quick_rs232 serial device between NUM_REQ on-chip requesters.
- Arbitrates round-robin and grants the channel for a burst of bytes.
- Sequences quick_rs232's tx_transaction / tx_data / tx_data_ready / tx_data_copied / tx_busy handshake on behalf of the winner.
- Sits between the application clients and the quick_rs232 instance, in the same clock domain.

---
 rtl/rs232_tx_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
// Shares the single transmit channel of a quick_rs232 instance between
// NUM_REQ on-chip requesters. Arbitration is round-robin; the winner keeps
// the channel for a burst of up to MAX_BURST bytes (0 = unlimited), and the
// arbiter runs the tx_transaction / tx_data / tx_data_ready / tx_data_copied /
// tx_busy handshake on its behalf. Same clock domain as quick_rs232.
//
// Optional build macro: RS232_TX_ARB_TIMEOUT_EN
//   Adds parameter COPY_TIMEOUT and output tx_timeout_err. A byte that is not
//   copied within COPY_TIMEOUT cycles is abandoned (no ack) and the grant is
//   drained. Without the macro WAIT_COPY waits indefinitely.
module rs232_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BYTE_LEN  = 8,
    parameter int MAX_BURST = 16
`ifdef RS232_TX_ARB_TIMEOUT_EN
    ,
    parameter int COPY_TIMEOUT = 100000
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BYTE_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         tx_transaction,
    output logic [BYTE_LEN-1:0]          tx_data,
    output logic                         tx_data_ready,
    input  logic                         tx_data_copied,
    input  logic                         tx_busy
`ifdef RS232_TX_ARB_TIMEOUT_EN
    ,
    output logic                         tx_timeout_err
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam bit UNLIMITED_C = (MAX_BURST == 0);
    localparam logic [CNT_W-1:0]   BURST_LIM_C = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0]   LAST_RST_C  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0_C  = {{(NUM_REQ-1){1'b0}}, 1'b1};

`ifdef RS232_TX_ARB_TIMEOUT_EN
    localparam int TO_W = (COPY_TIMEOUT > 1) ? $clog2(COPY_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LIM_C = TO_W'(COPY_TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANTED   = 2'd1,
        ST_WAIT_COPY = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       last_r;
    logic [IDX_W-1:0]       owner_r;
    logic [CNT_W-1:0]       burst_cnt_r;
    logic [NUM_REQ-1:0]     grant_r;
    logic [NUM_REQ-1:0]     req_ack_r;
    logic                   tx_transaction_r;
    logic [BYTE_LEN-1:0]    tx_data_r;
    logic                   tx_data_ready_r;
`ifdef RS232_TX_ARB_TIMEOUT_EN
    logic [TO_W-1:0]        to_cnt_r;
    logic                   tx_timeout_err_r;
`endif

    logic [IDX_W-1:0]       winner_s;
    logic                   found_s;
    logic [IDX_W-1:0]       cand_idx_s;
    int                     cand_v;
    logic                   owner_req_s;
    logic                   owner_valid_s;
    logic [BYTE_LEN-1:0]    owner_data_s;
    logic                   burst_ok_s;

    // Round-robin pick: first requesting index after the last owner, wrapping.
    always_comb begin
        winner_s   = last_r;
        found_s    = 1'b0;
        cand_v     = 0;
        cand_idx_s = last_r;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_v     = (int'(last_r) + k) % NUM_REQ;
            cand_idx_s = IDX_W'(cand_v);
            if (!found_s && req[cand_idx_s]) begin
                winner_s = cand_idx_s;
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
                found_s  = found_s;
            end
        end
    end

    // Owner's request lines and byte; other requesters are never looked at.
    always_comb begin
        owner_req_s   = req[owner_r];
        owner_valid_s = req_valid[owner_r];
        owner_data_s  = req_data[int'(owner_r)*BYTE_LEN +: BYTE_LEN];
    end

    // Burst budget: another byte may start only while below the limit.
    always_comb begin
        if (UNLIMITED_C) begin
            burst_ok_s = 1'b1;
        end else begin
            burst_ok_s = (burst_cnt_r < BURST_LIM_C);
        end
    end

    // Arbitration / handshake FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            last_r           <= LAST_RST_C;
            owner_r          <= '0;
            burst_cnt_r      <= '0;
            grant_r          <= '0;
            req_ack_r        <= '0;
            tx_transaction_r <= 1'b0;
            tx_data_r        <= '0;
            tx_data_ready_r  <= 1'b0;
`ifdef RS232_TX_ARB_TIMEOUT_EN
            to_cnt_r         <= '0;
            tx_timeout_err_r <= 1'b0;
`endif
        end else begin
            // ack and error are single-cycle pulses
            req_ack_r        <= '0;
`ifdef RS232_TX_ARB_TIMEOUT_EN
            tx_timeout_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        owner_r          <= winner_s;
                        grant_r          <= ONE_HOT0_C << winner_s;
                        tx_transaction_r <= 1'b1;
                        burst_cnt_r      <= '0;
                        state_r          <= ST_GRANTED;
                    end else begin
                        state_r          <= ST_IDLE;
                    end
                end

                ST_GRANTED: begin
                    if (|req_ack_r) begin
                        // ack cycle: requester is still swapping in its next byte
                        state_r         <= ST_GRANTED;
                    end else if (owner_valid_s && burst_ok_s) begin
                        tx_data_r       <= owner_data_s;
                        tx_data_ready_r <= 1'b1;
`ifdef RS232_TX_ARB_TIMEOUT_EN
                        to_cnt_r        <= '0;
`endif
                        state_r         <= ST_WAIT_COPY;
                    end else if (!owner_req_s || !burst_ok_s) begin
                        state_r         <= ST_DRAIN;
                    end else begin
                        state_r         <= ST_GRANTED;
                    end
                end

                ST_WAIT_COPY: begin
                    if (tx_data_copied) begin
                        tx_data_ready_r <= 1'b0;
                        req_ack_r       <= grant_r;
                        if (burst_cnt_r != BURST_LIM_C) begin
                            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                        end else begin
                            burst_cnt_r <= burst_cnt_r;
                        end
                        state_r         <= ST_GRANTED;
                    end
`ifdef RS232_TX_ARB_TIMEOUT_EN
                    else if (to_cnt_r == TO_LIM_C) begin
                        // byte abandoned: no ack, give the channel back
                        tx_data_ready_r  <= 1'b0;
                        tx_timeout_err_r <= 1'b1;
                        state_r          <= ST_DRAIN;
                    end else begin
                        to_cnt_r         <= to_cnt_r + TO_W'(1);
                        state_r          <= ST_WAIT_COPY;
                    end
`else
                    else begin
                        state_r <= ST_WAIT_COPY;
                    end
`endif
                end

                ST_DRAIN: begin
                    if (!tx_busy) begin
                        tx_transaction_r <= 1'b0;
                        grant_r          <= '0;
                        last_r           <= owner_r;
                        state_r          <= ST_IDLE;
                    end else begin
                        state_r          <= ST_DRAIN;
                    end
                end

                default: begin
                    tx_transaction_r <= 1'b0;
                    tx_data_ready_r  <= 1'b0;
                    grant_r          <= '0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack        = req_ack_r;
    assign grant          = grant_r;
    assign tx_transaction = tx_transaction_r;
    assign tx_data        = tx_data_r;
    assign tx_data_ready  = tx_data_ready_r;
`ifdef RS232_TX_ARB_TIMEOUT_EN
    assign tx_timeout_err = tx_timeout_err_r;
`endif

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed self-checking bench for rs232_tx_arbiter. A quick_rs232 model
// copies each byte 3 cycles after tx_data_ready and holds tx_busy for
// busy_len cycles; requesters present bytes from per-requester queues.
`timescale 1ns/1ps
module tb_rs232_tx_arbiter;

    localparam int NR = 4;
    localparam int BL = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_valid;
    logic [NR*BL-1:0]  req_data;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     grant;
    logic              tx_transaction;
    logic [BL-1:0]     tx_data;
    logic              tx_data_ready;
    logic              tx_data_copied;
    logic              tx_busy;
`ifdef RS232_TX_ARB_TIMEOUT_EN
    logic              tx_timeout_err;
`endif

    rs232_tx_arbiter #(
        .NUM_REQ(NR), .BYTE_LEN(BL), .MAX_BURST(16)
`ifdef RS232_TX_ARB_TIMEOUT_EN
        , .COPY_TIMEOUT(50)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_valid(req_valid),
        .req_data(req_data), .req_ack(req_ack), .grant(grant),
        .tx_transaction(tx_transaction), .tx_data(tx_data),
        .tx_data_ready(tx_data_ready), .tx_data_copied(tx_data_copied),
        .tx_busy(tx_busy)
`ifdef RS232_TX_ARB_TIMEOUT_EN
        , .tx_timeout_err(tx_timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0]  byte_q [NR][$];
    logic [11:0] sent_q [$];
    int ack_cnt [NR];
    int bad_ack, gap_viol, txn_viol;
    logic [NR-1:0] prev_grant;
    int rdy_age, busy_c, busy_len;
    bit copy_en;
    logic [NR-1:0] drop_mask, dropped;

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) begin
            if (byte_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic apply_reqs();
        for (int i = 0; i < NR; i++) begin
            if (byte_q[i].size() > 0) begin
                req[i] = !dropped[i];
                req_valid[i] = 1'b1;
                req_data[i*BL +: BL] = byte_q[i][0];
            end else begin
                req[i] = 1'b0;
                req_valid[i] = 1'b0;
                req_data[i*BL +: BL] = 8'h00;
                dropped[i] = 1'b0;
            end
        end
    endtask

    // One clock: sample outputs, update monitors, device model and requesters.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i] === 1'b1) begin
                ack_cnt[i]++;
                if (grant[i] !== 1'b1) bad_ack++;
                if (byte_q[i].size() > 0) void'(byte_q[i].pop_front());
            end
        end
        if (grant != prev_grant && prev_grant != 4'b0000 && grant != 4'b0000) gap_viol++;
        if (tx_transaction !== (grant != 4'b0000)) txn_viol++;
        prev_grant = grant;
        tx_data_copied = 1'b0;
        if (busy_c > 0) busy_c--;
        tx_busy = (busy_c > 0);
        if (tx_data_ready === 1'b1 && copy_en) begin
            rdy_age++;
            if (rdy_age == 3) begin
                tx_data_copied = 1'b1;
                rdy_age = 0;
                sent_q.push_back({grant, tx_data});
                busy_c = busy_len;
                tx_busy = 1'b1;
            end
        end else begin
            rdy_age = 0;
        end
        if (tx_data_copied) begin
            for (int i = 0; i < NR; i++) begin
                if (drop_mask[i] && grant[i]) begin
                    dropped[i] = 1'b1;
                    while (byte_q[i].size() > 1) void'(byte_q[i].pop_back());
                end
            end
        end
        apply_reqs();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) begin
            byte_q[i].delete();
            ack_cnt[i] = 0;
        end
        sent_q.delete();
        bad_ack = 0; gap_viol = 0; txn_viol = 0;
        drop_mask = '0; dropped = '0;
        copy_en = 1'b1; busy_len = 2; rdy_age = 0;
    endtask

    task automatic run_until_idle(input int max_cyc, input string name);
        int k;
        k = 0;
        while (!(all_empty() && grant == 4'b0000) && k < max_cyc) begin
            step();
            k++;
        end
        n_cmp++;
        if (!(all_empty() && grant == 4'b0000)) begin
            n_fail++;
            $display("FAIL %s: not idle after %0d cycles, grant=%b required 0000", name, k, grant);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_cmp++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
        n_cmp++; if (tx_transaction !== 1'b0) begin n_fail++; $display("FAIL reset_txn: got %b want 0", tx_transaction); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", tx_data); end
        n_cmp++; if (tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", tx_data_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_all();
        byte_q[2].push_back(8'hA5);
        apply_reqs();
        step();
        n_cmp++; if (grant !== 4'b0100 || tx_transaction !== 1'b1) begin n_fail++; $display("FAIL single_grant: grant=%b txn=%b want 0100/1", grant, tx_transaction); end
        n_cmp++; if (tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL single_early_ready: got %b want 0", tx_data_ready); end
        step();
        n_cmp++; if (tx_data_ready !== 1'b1 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: ready=%b data=%h want 1/a5", tx_data_ready, tx_data); end
        step(); step(); step();
        n_cmp++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", req_ack); end
        step();
        n_cmp++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0000", req_ack); end
        step();
        n_cmp++; if (grant !== 4'b0100 || tx_transaction !== 1'b1) begin n_fail++; $display("FAIL single_drain: grant=%b txn=%b want 0100/1", grant, tx_transaction); end
        step();
        n_cmp++; if (grant !== 4'b0000 || tx_transaction !== 1'b0) begin n_fail++; $display("FAIL single_release: grant=%b txn=%b want 0000/0", grant, tx_transaction); end
        n_cmp++; if (ack_cnt[2] !== 1) begin n_fail++; $display("FAIL single_ack_count: got %0d want 1", ack_cnt[2]); end
    endtask

    task automatic test_round_robin();
        logic [11:0] exp_v [4];
        exp_v = '{12'h111, 12'h112, 12'h221, 12'h222};
        clear_all();
        byte_q[0].push_back(8'h11); byte_q[0].push_back(8'h12);
        byte_q[1].push_back(8'h21); byte_q[1].push_back(8'h22);
        apply_reqs();
        run_until_idle(200, "rr_done");
        n_cmp++; if (sent_q.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d bytes want 4", sent_q.size()); end
        for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
            n_cmp++; if (sent_q[i] !== exp_v[i]) begin n_fail++; $display("FAIL rr_byte%0d: got %h want %h", i, sent_q[i], exp_v[i]); end
        end
        n_cmp++; if (ack_cnt[0] !== 2 || ack_cnt[1] !== 2) begin n_fail++; $display("FAIL rr_acks: got %0d/%0d want 2/2", ack_cnt[0], ack_cnt[1]); end
        n_cmp++; if (gap_viol !== 0 || bad_ack !== 0 || txn_viol !== 0) begin n_fail++; $display("FAIL rr_rules: gap=%0d bad_ack=%0d txn=%0d want 0/0/0", gap_viol, bad_ack, txn_viol); end
    endtask

    task automatic test_burst_limit();
        logic [11:0] exp_v [21];
        for (int i = 0; i < 16; i++) exp_v[i] = 12'h830 + 12'(i);
        exp_v[16] = 12'h251;
        for (int i = 17; i < 21; i++) exp_v[i] = 12'h840 + 12'(i - 17);
        clear_all();
        for (int i = 0; i < 20; i++) byte_q[3].push_back(8'h30 + 8'(i));
        byte_q[1].push_back(8'h51);
        apply_reqs();
        run_until_idle(1000, "burst_done");
        n_cmp++; if (sent_q.size() != 21) begin n_fail++; $display("FAIL burst_count: got %0d bytes want 21", sent_q.size()); end
        for (int i = 0; i < 21 && i < sent_q.size(); i++) begin
            n_cmp++; if (sent_q[i] !== exp_v[i]) begin n_fail++; $display("FAIL burst_byte%0d: got %h want %h", i, sent_q[i], exp_v[i]); end
        end
        n_cmp++; if (ack_cnt[3] !== 20 || ack_cnt[1] !== 1) begin n_fail++; $display("FAIL burst_acks: got %0d/%0d want 20/1", ack_cnt[3], ack_cnt[1]); end
        n_cmp++; if (gap_viol !== 0 || bad_ack !== 0 || txn_viol !== 0) begin n_fail++; $display("FAIL burst_rules: gap=%0d bad_ack=%0d txn=%0d want 0/0/0", gap_viol, bad_ack, txn_viol); end
    endtask

    task automatic test_reset_mid();
        int k;
        // move the pointer to 1 so that, without a pointer reset, req[2] would win next
        clear_all();
        byte_q[1].push_back(8'h55);
        apply_reqs();
        run_until_idle(100, "rstmid_prelude");
        clear_all();
        copy_en = 1'b0;
        byte_q[2].push_back(8'h77);
        apply_reqs();
        k = 0;
        while (tx_data_ready !== 1'b1 && k < 20) begin step(); k++; end
        n_cmp++; if (tx_data_ready !== 1'b1 || tx_data !== 8'h77) begin n_fail++; $display("FAIL rstmid_wait: ready=%b data=%h want 1/77", tx_data_ready, tx_data); end
        rst = 1'b1;
        step();
        n_cmp++; if ({grant, req_ack, tx_transaction, tx_data, tx_data_ready} !== 18'h0) begin
            n_fail++; $display("FAIL rstmid_outputs: grant=%b ack=%b txn=%b data=%h ready=%b want all 0", grant, req_ack, tx_transaction, tx_data, tx_data_ready);
        end
        rst = 1'b0;
        clear_all();
        byte_q[1].push_back(8'h61);
        byte_q[2].push_back(8'h62);
        apply_reqs();
        run_until_idle(200, "rstmid_done");
        n_cmp++; if (sent_q.size() != 2) begin n_fail++; $display("FAIL rstmid_count: got %0d bytes want 2", sent_q.size()); end
        else begin
            n_cmp++; if (sent_q[0] !== 12'h261 || sent_q[1] !== 12'h462) begin n_fail++; $display("FAIL rstmid_order: got %h,%h want 261,462", sent_q[0], sent_q[1]); end
        end
    endtask

    task automatic test_drop_on_copy();
        int k;
        clear_all();
        busy_len = 10;
        drop_mask = 4'b0010;
        byte_q[1].push_back(8'h81);
        byte_q[1].push_back(8'h82);
        apply_reqs();
        k = 0;
        while (tx_data_copied !== 1'b1 && k < 20) begin step(); k++; end
        n_cmp++; if (tx_data_copied !== 1'b1) begin n_fail++; $display("FAIL drop_copy_seen: got %b want 1", tx_data_copied); end
        for (int j = 0; j < 10; j++) step();
        n_cmp++; if (tx_transaction !== 1'b1 || grant !== 4'b0010) begin n_fail++; $display("FAIL drop_busy_hold: txn=%b grant=%b want 1/0010", tx_transaction, grant); end
        step();
        n_cmp++; if (tx_transaction !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL drop_release: txn=%b grant=%b want 0/0000", tx_transaction, grant); end
        n_cmp++; if (ack_cnt[1] !== 1 || bad_ack !== 0) begin n_fail++; $display("FAIL drop_ack: count=%0d bad=%0d want 1/0", ack_cnt[1], bad_ack); end
        n_cmp++; if (sent_q.size() != 1 || byte_q[1].size() != 0) begin n_fail++; $display("FAIL drop_bytes: sent=%0d left=%0d want 1/0", sent_q.size(), byte_q[1].size()); end
        else begin
            n_cmp++; if (sent_q[0] !== 12'h281) begin n_fail++; $display("FAIL drop_byte: got %h want 281", sent_q[0]); end
        end
    endtask

`ifdef RS232_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        clear_all();
        copy_en = 1'b0;
        byte_q[0].push_back(8'h99);
        apply_reqs();
        k = 0;
        while (tx_data_ready !== 1'b1 && k < 20) begin step(); k++; end
        k = 0;
        while (tx_timeout_err !== 1'b1 && k < 100) begin step(); k++; end
        n_cmp++; if (k != 50) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want 50", k); end
        n_cmp++; if (tx_data_ready !== 1'b0 || req_ack !== 4'b0000) begin n_fail++; $display("FAIL timeout_state: ready=%b ack=%b want 0/0000", tx_data_ready, req_ack); end
        step();
        n_cmp++; if (tx_timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b want 0", tx_timeout_err); end
        byte_q[0].delete();
        apply_reqs();
        run_until_idle(50, "timeout_release");
        n_cmp++; if (ack_cnt[0] !== 0) begin n_fail++; $display("FAIL timeout_noack: got %0d want 0", ack_cnt[0]); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = '0; req_valid = '0; req_data = '0;
        tx_data_copied = 1'b0; tx_busy = 1'b0;
        prev_grant = '0; busy_c = 0;
        clear_all();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_limit();
        test_reset_mid();
        test_drop_on_copy();
`ifdef RS232_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
